// File: rtl/fifo_byte_packer_if.sv
// Byte-stream / FIFO write-port bundle for fifo_byte_packer.
// master drives the byte stream and FIFO status; slave is the packer.
interface fifo_byte_packer_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              EN;
    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              flush;
    logic              flush_done;
    logic              FULL;
    logic              EMPTY;
    logic              RD;
    logic              WR;
    logic [WORD_W-1:0] dataOut;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output EN, byte_in, byte_valid, flush, FULL, EMPTY, RD,
        input  byte_ready, flush_done, WR, dataOut, wr_count
    );

    modport slave (
        input  EN, byte_in, byte_valid, flush, FULL, EMPTY, RD,
        output byte_ready, flush_done, WR, dataOut, wr_count
    );
endinterface

// File: rtl/fifo_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words for the 8-deep FIFO,
// holding each word until the FIFO really takes it (read has priority there).
module fifo_byte_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input logic               Clk,
    input logic               Rst,
    fifo_byte_packer_if.slave bus
);
    localparam int unsigned LANE_W = 2;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic [LANE_W-1:0] lane;
    logic [ACC_W-1:0]  acc;
    logic [WORD_W-1:0] out_q;
    logic              pending;
    logic              flush_done_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              wr_c;
    logic              wr_ok;
    logic              slot_free;
    logic              ready_c;
    logic              acc_ok;
    logic              flush_act;
    logic              flush_exec;
    logic [WORD_W-1:0] pad_word;

    // A write is lost whenever the FIFO performs a read in the same cycle.
    assign wr_c       = bus.EN && pending && !bus.FULL;
    assign wr_ok      = wr_c && !(bus.RD && !bus.EMPTY);
    assign slot_free  = !pending || wr_ok;
    assign ready_c    = !Rst && bus.EN && !bus.flush && ((lane != LANE_W'(3)) || slot_free);
    assign acc_ok     = bus.byte_valid && ready_c;
    // The flush_done cycle still sees the old request level, so it is masked.
    assign flush_act  = bus.EN && bus.flush && !flush_done_q;
    assign flush_exec = flush_act && ((lane == LANE_W'(0)) || slot_free);

    // Partial word: held bytes in the low lanes, pad fill above.
    always_comb begin
        pad_word = {4{PAD_BYTE}};
        if (lane > LANE_W'(0)) pad_word[7:0]   = acc[7:0];
        if (lane > LANE_W'(1)) pad_word[15:8]  = acc[15:8];
        if (lane > LANE_W'(2)) pad_word[23:16] = acc[23:16];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            lane         <= '0;
            acc          <= '0;
            out_q        <= '0;
            pending      <= 1'b0;
            flush_done_q <= 1'b0;
            cnt_q        <= '0;
        end else if (bus.EN) begin
            flush_done_q <= flush_exec;
            if (wr_ok) begin
                pending <= 1'b0;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (acc_ok) begin
                case (lane)
                    LANE_W'(0): begin acc[7:0]   <= bus.byte_in; lane <= LANE_W'(1); end
                    LANE_W'(1): begin acc[15:8]  <= bus.byte_in; lane <= LANE_W'(2); end
                    LANE_W'(2): begin acc[23:16] <= bus.byte_in; lane <= LANE_W'(3); end
                    default: begin
                        out_q   <= {bus.byte_in, acc};
                        pending <= 1'b1;
                        lane    <= '0;
                    end
                endcase
            end else if (flush_exec && (lane != LANE_W'(0))) begin
                out_q   <= pad_word;
                pending <= 1'b1;
                lane    <= '0;
            end
        end
    end

    assign bus.WR         = wr_c;
    assign bus.byte_ready = ready_c;
    assign bus.dataOut    = out_q;
    assign bus.flush_done = flush_done_q;
    assign bus.wr_count   = cnt_q;
endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: vector table plus hand sequences for
// FIFO back-pressure and asynchronous reset; a second instance uses PAD_BYTE FF.
module tb_fifo_byte_packer;
    logic Clk;
    logic Rst;
    int   checks;
    int   failures;

    fifo_byte_packer_if ifc ();
    fifo_byte_packer_if ifc_ff ();

    fifo_byte_packer #(.PAD_BYTE(8'h00)) u_dut    (.Clk(Clk), .Rst(Rst), .bus(ifc));
    fifo_byte_packer #(.PAD_BYTE(8'hFF)) u_dut_ff (.Clk(Clk), .Rst(Rst), .bus(ifc_ff));

    assign ifc_ff.EN         = ifc.EN;
    assign ifc_ff.byte_in    = ifc.byte_in;
    assign ifc_ff.byte_valid = ifc.byte_valid;
    assign ifc_ff.flush      = ifc.flush;
    assign ifc_ff.FULL       = ifc.FULL;
    assign ifc_ff.EMPTY      = ifc.EMPTY;
    assign ifc_ff.RD         = ifc.RD;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        en, valid;
        logic [7:0]  b;
        logic        fl, full, empty, rd;
        logic        rdy, wr;
        logic [31:0] dout;
        logic        fd;
        logic [15:0] cnt;
        logic [31:0] dout_ff;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic valid, input logic [7:0] b,
                                input logic fl, input logic full, input logic empty,
                                input logic rd, input logic rdy, input logic wr,
                                input logic [31:0] dout, input logic fd,
                                input logic [15:0] cnt, input logic [31:0] dout_ff);
        vec_t v;
        v.en = en; v.valid = valid; v.b = b; v.fl = fl; v.full = full;
        v.empty = empty; v.rd = rd; v.rdy = rdy; v.wr = wr; v.dout = dout;
        v.fd = fd; v.cnt = cnt; v.dout_ff = dout_ff;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Offer one byte expecting acceptance, then advance one cycle.
    task automatic send(input string nm, input logic [7:0] b);
        ifc.byte_valid = 1'b1;
        ifc.byte_in    = b;
        @(negedge Clk);
        chk(nm, 32'(ifc.byte_ready), 32'd1);
        @(posedge Clk); #1;
    endtask

    logic [31:0] exp_words [3];
    int          bi;
    int          nw;
    logic        saw_stall;

    initial begin
        checks = 0; failures = 0;
        Rst = 1'b1;
        ifc.EN = 1'b1; ifc.byte_valid = 1'b0; ifc.byte_in = 8'h00; ifc.flush = 1'b0;
        ifc.FULL = 1'b0; ifc.EMPTY = 1'b0; ifc.RD = 1'b0;

        //           en v  byte  fl fu em rd  rdy wr dout          fd cnt dout_ff
        vecs.push_back(mk(1,1,8'h11,0,0,0,0, 1,0,32'h0,        0,0, 32'h0));
        vecs.push_back(mk(1,1,8'h22,0,0,0,0, 1,0,32'h0,        0,0, 32'h0));
        vecs.push_back(mk(1,1,8'h33,0,0,0,0, 1,0,32'h0,        0,0, 32'h0));
        vecs.push_back(mk(1,1,8'h44,0,0,0,0, 1,0,32'h0,        0,0, 32'h0));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,1,32'h44332211, 0,0, 32'h44332211));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,0,32'h44332211, 0,1, 32'h44332211));
        vecs.push_back(mk(1,1,8'h01,0,0,0,0, 1,0,32'h44332211, 0,1, 32'h44332211));
        vecs.push_back(mk(1,1,8'h02,0,0,0,0, 1,0,32'h44332211, 0,1, 32'h44332211));
        vecs.push_back(mk(1,1,8'h03,0,0,0,0, 1,0,32'h44332211, 0,1, 32'h44332211));
        vecs.push_back(mk(1,1,8'h04,0,0,0,0, 1,0,32'h44332211, 0,1, 32'h44332211));
        // Reads steal the write for two cycles.
        vecs.push_back(mk(1,0,8'h00,0,0,0,1, 1,1,32'h04030201, 0,1, 32'h04030201));
        vecs.push_back(mk(1,0,8'h00,0,0,0,1, 1,1,32'h04030201, 0,1, 32'h04030201));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,1,32'h04030201, 0,1, 32'h04030201));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,0,32'h04030201, 0,2, 32'h04030201));
        // Two-byte packet flushed.
        vecs.push_back(mk(1,1,8'hAA,0,0,0,0, 1,0,32'h04030201, 0,2, 32'h04030201));
        vecs.push_back(mk(1,1,8'hBB,0,0,0,0, 1,0,32'h04030201, 0,2, 32'h04030201));
        vecs.push_back(mk(1,0,8'h00,1,0,0,0, 0,0,32'h04030201, 0,2, 32'h04030201));
        vecs.push_back(mk(1,0,8'h00,1,0,0,0, 0,1,32'h0000BBAA, 1,2, 32'hFFFFBBAA));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,0,32'h0000BBAA, 0,3, 32'hFFFFBBAA));
        // Flush with nothing held.
        vecs.push_back(mk(1,0,8'h00,1,0,0,0, 0,0,32'h0000BBAA, 0,3, 32'hFFFFBBAA));
        vecs.push_back(mk(1,0,8'h00,1,0,0,0, 0,0,32'h0000BBAA, 1,3, 32'hFFFFBBAA));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,0,32'h0000BBAA, 0,3, 32'hFFFFBBAA));
        // Flush waiting on a word blocked by FULL.
        vecs.push_back(mk(1,1,8'h55,0,1,0,0, 1,0,32'h0000BBAA, 0,3, 32'hFFFFBBAA));
        vecs.push_back(mk(1,1,8'h66,0,1,0,0, 1,0,32'h0000BBAA, 0,3, 32'hFFFFBBAA));
        vecs.push_back(mk(1,1,8'h77,0,1,0,0, 1,0,32'h0000BBAA, 0,3, 32'hFFFFBBAA));
        vecs.push_back(mk(1,1,8'h88,0,1,0,0, 1,0,32'h0000BBAA, 0,3, 32'hFFFFBBAA));
        vecs.push_back(mk(1,1,8'h99,0,1,0,0, 1,0,32'h88776655, 0,3, 32'h88776655));
        vecs.push_back(mk(1,0,8'h00,1,1,0,0, 0,0,32'h88776655, 0,3, 32'h88776655));
        vecs.push_back(mk(1,0,8'h00,1,0,0,0, 0,1,32'h88776655, 0,3, 32'h88776655));
        vecs.push_back(mk(1,0,8'h00,1,0,0,0, 0,1,32'h00000099, 1,4, 32'hFFFFFF99));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,0,32'h00000099, 0,5, 32'hFFFFFF99));
        // Disabled: byte offered but ignored.
        vecs.push_back(mk(0,1,8'h12,0,0,0,0, 0,0,32'h00000099, 0,5, 32'hFFFFFF99));
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 1,0,32'h00000099, 0,5, 32'hFFFFFF99));

        @(negedge Clk);
        chk("rst.byte_ready", 32'(ifc.byte_ready), 32'd0);
        chk("rst.WR",         32'(ifc.WR),         32'd0);
        chk("rst.dataOut",    ifc.dataOut,         32'd0);
        chk("rst.flush_done", 32'(ifc.flush_done), 32'd0);
        chk("rst.wr_count",   32'(ifc.wr_count),   32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            ifc.EN = vecs[i].en; ifc.byte_valid = vecs[i].valid; ifc.byte_in = vecs[i].b;
            ifc.flush = vecs[i].fl; ifc.FULL = vecs[i].full;
            ifc.EMPTY = vecs[i].empty; ifc.RD = vecs[i].rd;
            @(negedge Clk);
            chk($sformatf("v%0d.byte_ready", i), 32'(ifc.byte_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d.WR", i),         32'(ifc.WR),         32'(vecs[i].wr));
            chk($sformatf("v%0d.dataOut", i),    ifc.dataOut,         vecs[i].dout);
            chk($sformatf("v%0d.flush_done", i), 32'(ifc.flush_done), 32'(vecs[i].fd));
            chk($sformatf("v%0d.wr_count", i),   32'(ifc.wr_count),   32'(vecs[i].cnt));
            chk($sformatf("v%0d.dataOut_ff", i), ifc_ff.dataOut,      vecs[i].dout_ff);
            @(posedge Clk); #1;
        end

        // 12 bytes streamed while FULL holds for the first 10 cycles.
        exp_words[0] = 32'h13121110;
        exp_words[1] = 32'h17161514;
        exp_words[2] = 32'h1B1A1918;
        ifc.flush = 1'b0; ifc.RD = 1'b0; ifc.EN = 1'b1;
        bi = 0; nw = 0; saw_stall = 1'b0;
        for (int c = 0; c < 40 && (bi < 12 || nw < 3); c++) begin
            ifc.FULL       = (c < 10);
            ifc.byte_valid = (bi < 12);
            ifc.byte_in    = 8'h10 + 8'(bi);
            @(negedge Clk);
            if (ifc.WR && !(ifc.RD && !ifc.EMPTY)) begin
                if (nw < 3) chk($sformatf("stream.word%0d", nw), ifc.dataOut, exp_words[nw]);
                else        chk("stream.extra_WR", 32'(ifc.WR), 32'd0);
                nw++;
            end
            if (ifc.byte_valid && !ifc.byte_ready) saw_stall = 1'b1;
            if (ifc.byte_valid && ifc.byte_ready) bi++;
            @(posedge Clk); #1;
        end
        ifc.byte_valid = 1'b0;
        chk("stream.bytes", 32'(bi), 32'd12);
        chk("stream.words", 32'(nw), 32'd3);
        chk("stream.stall_seen", 32'(saw_stall), 32'd1);
        @(negedge Clk);
        chk("stream.wr_count", 32'(ifc.wr_count), 32'd8);
        chk("stream.idle_WR", 32'(ifc.WR), 32'd0);
        @(posedge Clk); #1;

        // Pending word plus partial word, then freeze and async reset.
        ifc.FULL = 1'b1;
        send("rst_seq.A1", 8'hA1); send("rst_seq.A2", 8'hA2);
        send("rst_seq.A3", 8'hA3); send("rst_seq.A4", 8'hA4);
        send("rst_seq.B1", 8'hB1); send("rst_seq.B2", 8'hB2);
        ifc.byte_valid = 1'b1; ifc.byte_in = 8'hEE; ifc.EN = 1'b0; ifc.FULL = 1'b0;
        @(negedge Clk);
        chk("freeze.byte_ready", 32'(ifc.byte_ready), 32'd0);
        chk("freeze.WR",         32'(ifc.WR),         32'd0);
        chk("freeze.dataOut",    ifc.dataOut,         32'hA4A3A2A1);
        @(posedge Clk); #1;
        ifc.byte_valid = 1'b0; ifc.EN = 1'b1; ifc.FULL = 1'b1;
        @(negedge Clk);
        chk("freeze.wr_count", 32'(ifc.wr_count), 32'd8);
        chk("freeze.ready_lane2", 32'(ifc.byte_ready), 32'd1);
        @(posedge Clk); #1;
        ifc.EN = 1'b0;
        #2 Rst = 1'b1;
        #1;
        chk("arst.WR",         32'(ifc.WR),         32'd0);
        chk("arst.dataOut",    ifc.dataOut,         32'd0);
        chk("arst.byte_ready", 32'(ifc.byte_ready), 32'd0);
        chk("arst.flush_done", 32'(ifc.flush_done), 32'd0);
        chk("arst.wr_count",   32'(ifc.wr_count),   32'd0);
        @(posedge Clk); #1;
        ifc.EN = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; ifc.FULL = 1'b0;
        send("post.C1", 8'hC1); send("post.C2", 8'hC2);
        send("post.C3", 8'hC3); send("post.C4", 8'hC4);
        ifc.byte_valid = 1'b0;
        @(negedge Clk);
        chk("post.WR",       32'(ifc.WR),       32'd1);
        chk("post.dataOut",  ifc.dataOut,       32'hC4C3C2C1);
        chk("post.wr_count", 32'(ifc.wr_count), 32'd0);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("post.wr_count1", 32'(ifc.wr_count), 32'd1);
        chk("post.WR_low",    32'(ifc.WR),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
